// File: rtl/sid_write_player_pkg.sv
// Shared types and constants for the sid write player: FSM encodings,
// command field widths and the packed command layout held in the FIFO.
package sid_write_player_pkg;

  localparam int WAIT_W = 16;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 8;
  localparam int CMD_W  = WAIT_W + ADDR_W + DATA_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ISSUE = 2'd2
  } state_t;

  // "wait" is a keyword, so the delay field is called ticks.
  typedef struct packed {
    logic [WAIT_W-1:0] ticks;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } cmd_t;

  function automatic cmd_t pack_cmd(input logic [WAIT_W-1:0] ticks,
                                    input logic [ADDR_W-1:0] addr,
                                    input logic [DATA_W-1:0] data);
    cmd_t c;
    c.ticks = ticks;
    c.addr  = addr;
    c.data  = data;
    return c;
  endfunction

endpackage

// File: rtl/sid_write_player_if.sv
// Host command stream plus the sid CPU-side bus, seen from the player.
// Signal names keep the player's i_/o_ perspective on both modports.
interface sid_write_player_if #(
  parameter int LW = 5
);
  import sid_write_player_pkg::*;

  logic              i_cmd_valid;
  logic              o_cmd_ready;
  logic [WAIT_W-1:0] i_cmd_wait;
  logic [ADDR_W-1:0] i_cmd_addr;
  logic [DATA_W-1:0] i_cmd_data;
  logic              i_run;
  logic              o_cs;
  logic              o_we;
  logic [ADDR_W-1:0] o_addr;
  logic [DATA_W-1:0] o_data;
  logic [LW-1:0]     o_level;
  logic              o_idle;

  // Host loader / bench side.
  modport master (
    output i_cmd_valid, i_cmd_wait, i_cmd_addr, i_cmd_data, i_run,
    input  o_cmd_ready, o_cs, o_we, o_addr, o_data, o_level, o_idle
  );

  // Player side.
  modport slave (
    input  i_cmd_valid, i_cmd_wait, i_cmd_addr, i_cmd_data, i_run,
    output o_cmd_ready, o_cs, o_we, o_addr, o_data, o_level, o_idle
  );

endinterface

// File: rtl/sid_write_player_sync_fifo.sv
// Register-array FIFO. Head data comes straight from the storage
// registers, so a word written on one edge is poppable on the next edge
// at the earliest. Fullness comes from the level counter; pointers wrap.
module sync_fifo
  import sid_write_player_pkg::*;
#(
  parameter int WIDTH = CMD_W,
  parameter int DEPTH = 16,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_din,
  output logic [WIDTH-1:0] o_dout,
  output logic [LW-1:0]    o_level
);

  localparam int            AW   = $clog2(DEPTH);
  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [LW-1:0]    r_level;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push && (r_level != FULL);
  assign w_do_pop  = i_pop && (r_level != '0);
  assign o_dout    = r_mem[r_rd_ptr];
  assign o_level   = r_level;

  // Storage write; contents need no reset since level gates every read.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_din;
  end

  // Pointers and occupancy; a simultaneous push and pop leaves level alone.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/sid_write_player.sv
// Timed register-write initiator for the sid CPU-side bus. Commands are
// queued in a FIFO, then each write is replayed after its tick delay,
// aligned to the 1 MHz phase-1 enable that sid samples writes on.
//
// state   | meaning
// S_IDLE  | waiting for run high and a queued command
// S_WAIT  | counting run-qualified ticks down to zero
// S_ISSUE | bus asserted, held until the tick cycle sid captures
module sid_write_player
  import sid_write_player_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clk_1mhz_ph1_en,
  sid_write_player_if.slave   bus
);

  localparam logic [LW-1:0] FULL = LW'(DEPTH);

  state_t            r_state,    w_state_nxt;
  logic [WAIT_W-1:0] r_cnt,      w_cnt_nxt;
  logic [ADDR_W-1:0] r_lat_addr, w_lat_addr_nxt;
  logic [DATA_W-1:0] r_lat_data, w_lat_data_nxt;
  logic              r_cs,       w_cs_nxt;
  logic              r_we,       w_we_nxt;
  logic [ADDR_W-1:0] r_addr,     w_addr_nxt;
  logic [DATA_W-1:0] r_data,     w_data_nxt;

  logic              w_push;
  logic              w_pop;
  logic              w_ready;
  logic [LW-1:0]     w_level;
  cmd_t              w_head;
  cmd_t              w_cmd_in;

  assign w_ready  = (w_level != FULL);
  assign w_push   = bus.i_cmd_valid && w_ready;
  assign w_cmd_in = pack_cmd(bus.i_cmd_wait, bus.i_cmd_addr, bus.i_cmd_data);

  sync_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH),
    .LW    (LW)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_cmd_in),
    .o_dout  (w_head),
    .o_level (w_level)
  );

  // Next-state, counter and bus decisions; everything holds by default.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_lat_addr_nxt = r_lat_addr;
    w_lat_data_nxt = r_lat_data;
    w_cs_nxt       = r_cs;
    w_we_nxt       = r_we;
    w_addr_nxt     = r_addr;
    w_data_nxt     = r_data;
    w_pop          = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (bus.i_run && (w_level != '0)) begin
          w_pop          = 1'b1;
          w_cnt_nxt      = w_head.ticks;
          w_lat_addr_nxt = w_head.addr;
          w_lat_data_nxt = w_head.data;
          w_state_nxt    = S_WAIT;
        end
      end
      S_WAIT: begin
        // A tick coinciding with cnt == 0 is deliberately ignored; the
        // write itself is the next tick, seen from ISSUE.
        if (r_cnt == '0) begin
          w_cs_nxt    = 1'b1;
          w_we_nxt    = 1'b1;
          w_addr_nxt  = r_lat_addr;
          w_data_nxt  = r_lat_data;
          w_state_nxt = S_ISSUE;
        end else if (clk_1mhz_ph1_en && bus.i_run) begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      S_ISSUE: begin
        // Completes even with run low so sid never sees a truncated write.
        if (clk_1mhz_ph1_en) begin
          w_cs_nxt    = 1'b0;
          w_we_nxt    = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_cs_nxt    = 1'b0;
        w_we_nxt    = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, counter, latched command and bus registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_lat_addr <= '0;
      r_lat_data <= '0;
      r_cs       <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_data     <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_lat_addr <= w_lat_addr_nxt;
      r_lat_data <= w_lat_data_nxt;
      r_cs       <= w_cs_nxt;
      r_we       <= w_we_nxt;
      r_addr     <= w_addr_nxt;
      r_data     <= w_data_nxt;
    end
  end

  assign bus.o_cmd_ready = w_ready;
  assign bus.o_cs        = r_cs;
  assign bus.o_we        = r_we;
  assign bus.o_addr      = r_addr;
  assign bus.o_data      = r_data;
  assign bus.o_level     = w_level;
  assign bus.o_idle      = (r_state == S_IDLE) && (w_level == '0);

endmodule

// File: doc/sid_write_player.md
# sid_write_player

Timed register-write initiator for the `sid` block's CPU-side bus. It accepts queued commands from a host loader over a valid/ready stream. Each command holds a tick delay, a register address and a data byte. The block replays each write onto the sid `cs/we/addr/data` bus, aligned to `clk_1mhz_ph1_en`. It sits beside the CPU as a second bus master for tune playback; arbitration with the CPU is outside this block.

## Interface
Parameters:
- `DEPTH`, 16: command FIFO entries; must be a power of two, at least 2.
- `LW`, `$clog2(DEPTH+1)`: width of the FIFO level output.

Ports:
- `clk`  in  1: system clock; one clock domain.
- `rst`  in  1: synchronous, active-high reset.
- `clk_1mhz_ph1_en`  in  1: 1 MHz tick enable. The same strobe that sid samples writes on. Ticks are spaced at least 4 clk cycles apart.
- `i_cmd_valid`  in  1: command offered.
- `o_cmd_ready`  out  1: FIFO not full.
- `i_cmd_wait`  in  16: ticks to skip before the write.
- `i_cmd_addr`  in  5: sid register index.
- `i_cmd_data`  in  8: write data.
- `i_run`  in  1: playback enable.
- `o_cs`  out  1: sid chip select.
- `o_we`  out  1: sid write enable.
- `o_addr`  out  5: sid address.
- `o_data`  out  8: sid write data.
- `o_level`  out  LW: FIFO occupancy.
- `o_idle`  out  1: FIFO empty and FSM in IDLE.

## Operation
- **Push:** a command is pushed when `i_cmd_valid & o_cmd_ready` at a clk edge. `o_cmd_ready = (level != DEPTH)`, combinational from the level.
- **FSM states:** IDLE, WAIT, ISSUE. Tick counter `cnt` is 16 bits.
- **IDLE:**
  - If `i_run` is high and the FIFO is non-empty: pop the head, load `cnt <= wait`, latch addr/data, go to WAIT.
  - Otherwise stay in IDLE.
- **WAIT:**
  - If `cnt == 0`: go to ISSUE and, on the same edge, set `o_cs = o_we = 1` and drive the latched addr/data. A tick in this cycle is not counted.
  - Otherwise, if a tick occurs and `i_run` is high: `cnt <= cnt - 1`.
  - If `i_run` is low, the counter holds.
- **ISSUE:**
  - The bus stays asserted until a cycle with `clk_1mhz_ph1_en` high. That cycle is the write; sid captures it.
  - At the end of that cycle: `o_cs <= 0`, `o_we <= 0`, go to IDLE.
  - ISSUE always completes, regardless of `i_run`.
- **Delay semantics:** `wait = N` places the write on the (N+1)-th tick seen after entering WAIT, excluding the tick in the WAIT cycle where `cnt == 0`.
- **Bus outputs:**
  - `o_addr`/`o_data` hold their last value when `o_cs` is low.
  - Exactly one tick cycle has `o_cs & o_we` per command.
- **Level:** `o_level` increments on a push alone, decrements on a pop alone, and is unchanged on a simultaneous push and pop.
- **`o_idle`:** `o_idle = (state == IDLE) & (level == 0)`.

## Timing
- **Reset values:** `o_cs=0`, `o_we=0`, `o_addr=0`, `o_data=0`, `o_level=0`, `o_idle=1`, `o_cmd_ready=1`, state IDLE, `cnt=0`.
- **Reset mid-operation:** the FIFO is flushed and the bus is deasserted at the reset edge. A write in flight is dropped.
- **Push-to-pop latency:** a command pushed into an empty FIFO is popped at the earliest on the next edge (no fall-through).
- **Command spacing:** minimum 3 clk cycles from pop to bus assert with `wait = 0` (pop, WAIT, assert edge). Back-to-back commands with `wait = 0` land on consecutive ticks only if the tick spacing is at least 4 cycles.
- **Full FIFO:** `o_cmd_ready` is low. A push offered in the same cycle as a pop is refused; the host retries next cycle.
- **Wrap-around:** read and write pointers are `$clog2(DEPTH)` bits and wrap naturally; fullness is determined from the level counter.

## Structure
- Sub-module `sync_fifo`: parameterised width (29) and depth. Ports: push/pop, data in/out, level. First-word data is registered; no fall-through.
- Shared package constants:
  - FSM state encodings `S_IDLE`, `S_WAIT`, `S_ISSUE`.
  - Command field widths: wait 16, addr 5, data 8.
- The top level holds the FSM, the tick counter and the bus registers.

## Test plan
- **Reset:** apply reset for 2 cycles → all outputs at reset values. Push 3 commands, then assert reset mid-WAIT → level 0 and no `o_cs` pulse within the next 10 ticks.
- **Single write, zero wait:** push `{wait=0, addr=0x04, data=0x41}` with ticks every 8 clk → `o_cs & o_we` high for exactly one tick cycle with addr 0x04 and data 0x41, on the first tick after ISSUE is entered.
- **Delay:** push `wait=3`, `addr=0x18` → the write lands on the 4th counted tick. Push `wait=0xFFFF` → the write lands on tick 65536.
- **Backpressure:** DEPTH=16, `i_run=0`, push 17 commands → `o_cmd_ready` is low after 16, `o_level=16`, and the 17th is held. Raise `i_run` → all 16 writes occur in order with no loss.
- **Pause:** drop `i_run` mid-WAIT with `cnt=5` for 20 ticks → the counter holds. On resume, the write lands 6 counted ticks later. Drop `i_run` in ISSUE → the write still completes.
- **Model checking:** random commands with random valid/run/tick spacing (at least 4 cycles) → the write sequence matches a reference queue. There is never more than one `o_cs` tick cycle per command, and `o_idle` is asserted when drained.
